// File: rtl/count_decoder.sv
// count_decoder: recovers hold/up/down/load ops from an observed counter bus and tracks lock.
// Optional HOLD_TIMEOUT_EN adds a stall flag raised after HOLD_LIMIT consecutive HOLD decodes.
module count_decoder #(
   parameter int WIDTH      = 4,
   parameter int JUMP_LIMIT = 3,
   parameter int LOCK_RUN   = 4,
   parameter int HOLD_LIMIT = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] count_in,
   output logic             op_valid,
   output logic [1:0]       op,
   output logic [WIDTH-1:0] load_val,
   output logic             locked,
   output logic [7:0]       jump_cnt
`ifdef HOLD_TIMEOUT_EN
   ,
   output logic             stall
`endif
);
   typedef enum logic [1:0] {SYNC, TRACK, LOST} state_t;
   localparam logic [1:0] OP_HOLD = 2'b00, OP_UP = 2'b01, OP_DOWN = 2'b10, OP_JUMP = 2'b11;
   localparam logic [7:0] JL = 8'(JUMP_LIMIT);
   localparam logic [7:0] LR = 8'(LOCK_RUN);

   if (WIDTH < 2 || JUMP_LIMIT < 1 || LOCK_RUN < 1 || HOLD_LIMIT < 1) begin : g_bad_param
      $error("count_decoder: illegal parameter value");
   end

   state_t           r_state;
   logic [WIDTH-1:0] r_prev;
   logic [7:0]       r_jrun;
   logic [7:0]       r_nrun;
   logic             w_dec;
   logic             w_jump;
   logic [1:0]       w_op;
   logic [WIDTH-1:0] w_inc;
   logic [WIDTH-1:0] w_decr;
   logic [7:0]       w_jrun_n;
   logic [7:0]       w_nrun_n;

   // Modulo arithmetic makes wrap-around steps decode as UP/DOWN.
   assign w_inc    = r_prev + WIDTH'(1);
   assign w_decr   = r_prev - WIDTH'(1);
   assign w_dec    = in_valid && r_state != SYNC;
   assign w_op     = (count_in == r_prev) ? OP_HOLD :
                     (count_in == w_inc)  ? OP_UP   :
                     (count_in == w_decr) ? OP_DOWN : OP_JUMP;
   assign w_jump   = w_op == OP_JUMP;
   assign w_jrun_n = !w_jump ? 8'd0 : (r_jrun >= JL) ? r_jrun : r_jrun + 8'd1;
   assign w_nrun_n = w_jump ? 8'd0 : (r_nrun >= LR) ? r_nrun : r_nrun + 8'd1;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state  <= SYNC;
         r_prev   <= '0;
         r_jrun   <= '0;
         r_nrun   <= '0;
         op_valid <= 1'b0;
         op       <= OP_HOLD;
         load_val <= '0;
         locked   <= 1'b0;
         jump_cnt <= '0;
      end else begin
         op_valid <= w_dec;
         if (in_valid) begin
            r_prev <= count_in;
            if (r_state == SYNC) begin
               r_state <= TRACK;
               locked  <= 1'b1;
            end else begin
               op     <= w_op;
               r_jrun <= w_jrun_n;
               if (w_jump) begin
                  load_val <= count_in;
                  if (jump_cnt != 8'hFF) jump_cnt <= jump_cnt + 8'd1;
               end
               if (r_state == TRACK && w_jrun_n >= JL) begin
                  r_state <= LOST;
                  locked  <= 1'b0;
                  r_nrun  <= '0;
               end else if (r_state == LOST && w_nrun_n >= LR) begin
                  r_state <= TRACK;
                  locked  <= 1'b1;
                  r_nrun  <= '0;
               end else begin
                  r_nrun <= (r_state == LOST) ? w_nrun_n : 8'd0;
               end
            end
         end
      end
   end

`ifdef HOLD_TIMEOUT_EN
   localparam int HW = $clog2(HOLD_LIMIT + 1);
   localparam logic [HW-1:0] HL = HW'(HOLD_LIMIT);
   logic [HW-1:0] r_hrun;
   logic [HW-1:0] w_hrun_n;

   assign w_hrun_n = (w_op != OP_HOLD) ? '0 : (r_hrun == HL) ? r_hrun : r_hrun + HW'(1);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_hrun <= '0;
         stall  <= 1'b0;
      end else if (w_dec) begin
         r_hrun <= w_hrun_n;
         stall  <= w_hrun_n == HL;
      end
   end
`endif
endmodule

// File: tb/tb_count_decoder.sv
// tb_count_decoder: directed checks of count_decoder with hand-computed expectations.
// Define HOLD_TIMEOUT_EN for both files to also exercise the stall flag.
module tb_count_decoder;
   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       in_valid = 1'b0;
   logic [3:0] count_in = '0;
   logic       op_valid;
   logic [1:0] op;
   logic [3:0] load_val;
   logic       locked;
   logic [7:0] jump_cnt;
`ifdef HOLD_TIMEOUT_EN
   logic       stall;
`endif
   int n_cmp = 0;
   int n_bad = 0;

   count_decoder #(.WIDTH(4), .JUMP_LIMIT(3), .LOCK_RUN(4), .HOLD_LIMIT(16)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .count_in(count_in),
      .op_valid(op_valid), .op(op), .load_val(load_val), .locked(locked),
`ifdef HOLD_TIMEOUT_EN
      .stall(stall),
`endif
      .jump_cnt(jump_cnt)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   // Drive one sample at a falling edge; returns at the next falling edge with its decode visible.
   task automatic send(input int v);
      in_valid = 1'b1;
      count_in = 4'(v);
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      in_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_reset();
      do_reset();
      n_cmp++; if (op_valid !== 1'b0) begin n_bad++; $display("FAIL reset_op_valid got=%b exp=0", op_valid); end
      n_cmp++; if (op !== 2'b00) begin n_bad++; $display("FAIL reset_op got=%b exp=00", op); end
      n_cmp++; if (load_val !== 4'd0) begin n_bad++; $display("FAIL reset_load_val got=%0d exp=0", load_val); end
      n_cmp++; if (locked !== 1'b0) begin n_bad++; $display("FAIL reset_locked got=%b exp=0", locked); end
      n_cmp++; if (jump_cnt !== 8'd0) begin n_bad++; $display("FAIL reset_jump_cnt got=%0d exp=0", jump_cnt); end
`ifdef HOLD_TIMEOUT_EN
      n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL reset_stall got=%b exp=0", stall); end
`endif
   endtask

   // Shared table runner for sample/expectation sequences starting from reset.
   task automatic run_seq(input string name, input int n, input int s[8], input logic v[8],
                          input logic [1:0] o[8], input logic l[8]);
      do_reset();
      for (int i = 0; i < n; i++) begin
         send(s[i]);
         n_cmp++; if (op_valid !== v[i]) begin n_bad++; $display("FAIL %s[%0d]_op_valid got=%b exp=%b", name, i, op_valid, v[i]); end
         if (v[i]) begin
            n_cmp++; if (op !== o[i]) begin n_bad++; $display("FAIL %s[%0d]_op got=%b exp=%b", name, i, op, o[i]); end
         end
         n_cmp++; if (locked !== l[i]) begin n_bad++; $display("FAIL %s[%0d]_locked got=%b exp=%b", name, i, locked, l[i]); end
      end
   endtask

   task automatic test_basic();
      run_seq("basic", 4, '{7,8,9,9,0,0,0,0}, '{0,1,1,1,0,0,0,0},
              '{2'b00,2'b01,2'b01,2'b00,2'b00,2'b00,2'b00,2'b00}, '{1,1,1,1,0,0,0,0});
      n_cmp++; if (jump_cnt !== 8'd0) begin n_bad++; $display("FAIL basic_jump_cnt got=%0d exp=0", jump_cnt); end
   endtask

   task automatic test_wrap();
      run_seq("wrap", 5, '{14,15,0,15,14,0,0,0}, '{0,1,1,1,1,0,0,0},
              '{2'b00,2'b01,2'b01,2'b10,2'b10,2'b00,2'b00,2'b00}, '{1,1,1,1,1,0,0,0});
      n_cmp++; if (jump_cnt !== 8'd0) begin n_bad++; $display("FAIL wrap_jump_cnt got=%0d exp=0", jump_cnt); end
   endtask

   task automatic test_load();
      run_seq("load", 4, '{3,4,10,11,0,0,0,0}, '{0,1,1,1,0,0,0,0},
              '{2'b00,2'b01,2'b11,2'b01,2'b00,2'b00,2'b00,2'b00}, '{1,1,1,1,0,0,0,0});
      n_cmp++; if (load_val !== 4'd10) begin n_bad++; $display("FAIL load_val got=%0d exp=10", load_val); end
      n_cmp++; if (jump_cnt !== 8'd1) begin n_bad++; $display("FAIL load_jump_cnt got=%0d exp=1", jump_cnt); end
   endtask

   task automatic test_back_to_back();
      run_seq("relock", 8, '{0,5,11,2,3,4,5,6}, '{0,1,1,1,1,1,1,1},
              '{2'b00,2'b11,2'b11,2'b11,2'b01,2'b01,2'b01,2'b01}, '{1,1,1,0,0,0,0,1});
      n_cmp++; if (jump_cnt !== 8'd3) begin n_bad++; $display("FAIL relock_jump_cnt got=%0d exp=3", jump_cnt); end
      n_cmp++; if (load_val !== 4'd2) begin n_bad++; $display("FAIL relock_load_val got=%0d exp=2", load_val); end
   endtask

   task automatic test_gaps_reset();
      int pulses = 0;
      do_reset();
      send(2);
      if (op_valid) pulses++;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         if (op_valid) pulses++;
      end
      send(3);
      if (op_valid) pulses++;
      n_cmp++; if (op !== 2'b01) begin n_bad++; $display("FAIL gap_op got=%b exp=01", op); end
      @(negedge clk);
      if (op_valid) pulses++;
      n_cmp++; if (pulses !== 1) begin n_bad++; $display("FAIL gap_pulses got=%0d exp=1", pulses); end
      send(9);
      n_cmp++; if (load_val !== 4'd9) begin n_bad++; $display("FAIL gap_jump_load got=%0d exp=9", load_val); end
      #2 rst_n = 1'b0;
      #1;
      n_cmp++; if ({op_valid, op, load_val, locked, jump_cnt} !== 16'd0) begin
         n_bad++;
         $display("FAIL async_reset got=%b/%b/%0d/%b/%0d exp=all zero", op_valid, op, load_val, locked, jump_cnt);
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      send(5);
      n_cmp++; if (op_valid !== 1'b0 || locked !== 1'b1) begin n_bad++; $display("FAIL resync got=%b/%b exp=0/1", op_valid, locked); end
      send(6);
      n_cmp++; if (op_valid !== 1'b1 || op !== 2'b01) begin n_bad++; $display("FAIL resync_up got=%b/%b exp=1/01", op_valid, op); end
   endtask

`ifdef HOLD_TIMEOUT_EN
   task automatic test_stall();
      do_reset();
      for (int i = 0; i < 16; i++) send(9);
      n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL stall_early got=%b exp=0", stall); end
      send(9);
      n_cmp++; if (stall !== 1'b1) begin n_bad++; $display("FAIL stall_set got=%b exp=1", stall); end
      repeat (3) @(negedge clk);
      n_cmp++; if (stall !== 1'b1) begin n_bad++; $display("FAIL stall_gap got=%b exp=1", stall); end
      send(10);
      n_cmp++; if (stall !== 1'b0 || op !== 2'b01) begin n_bad++; $display("FAIL stall_clear got=%b/%b exp=0/01", stall, op); end
   endtask
`endif

   initial begin
      test_reset();
      test_basic();
      test_wrap();
      test_load();
      test_back_to_back();
      test_gaps_reset();
`ifdef HOLD_TIMEOUT_EN
      test_stall();
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
